vfifo_sync_ctrl: RTL
====================

Name: vfifo_sync_ctrl

Overview:
- Single-clock FIFO controller that drives the simple dual-port RAM (`vfifo_dual_port_ram`, single-clock, single-write build).
- Write side drives RAM port A. Read side drives RAM port B, which has a registered address and combinational data out.
- Presents a show-ahead (first-word-fall-through) read interface: `rd_data` is valid whenever `empty`=0.
- Adds fill level, sticky overflow/underflow flags and a synchronous flush.

Parameters:
- DATA_WIDTH, 8, width of the data word.
- ADDR_WIDTH, 4, RAM address width; capacity = 2^ADDR_WIDTH entries.
- AF_THR, 2, almost-full threshold (optional feature only).
- AE_THR, 2, almost-empty threshold (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous flush; empties the FIFO and clears error flags.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- full  out  1  FIFO holds 2^ADDR_WIDTH entries.
- rd_en  in  1  read request (consumes `rd_data`).
- rd_data  out  DATA_WIDTH  head-of-FIFO data; equals `ram_q_b`.
- empty  out  1  FIFO holds 0 entries.
- fill  out  ADDR_WIDTH+1  number of stored entries.
- ovf  out  1  sticky: a write was attempted while full.
- udf  out  1  sticky: a read was attempted while empty.
- ram_adr_a  out  ADDR_WIDTH  RAM write address.
- ram_d_a  out  DATA_WIDTH  RAM write data.
- ram_we_a  out  1  RAM write enable.
- ram_adr_b  out  ADDR_WIDTH  RAM read address (the RAM registers it).
- ram_q_b  in  DATA_WIDTH  RAM read data.

Behaviour:
- State:
  - `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - `empty` = (`wr_ptr` == `rd_ptr`).
  - `full` = low bits equal and MSBs differ.
  - `fill` = `wr_ptr` − `rd_ptr`, modulo 2^(ADDR_WIDTH+1).
  - All flags are decoded from registers; no combinational path from `wr_en`/`rd_en` to the flags.
- Reset (`rst`=1, asynchronous): pointers 0, `empty`=1, `full`=0, `fill`=0, `ovf`=0, `udf`=0. `ram_we_a`=0 because `wr_en` is ignored during reset.
- Write accept: `wr_acc` = `wr_en` & ~`full` (pre-edge flag).
  - `ram_we_a` = `wr_acc`, `ram_adr_a` = `wr_ptr`[ADDR_WIDTH-1:0], `ram_d_a` = `wr_data` (combinational).
  - `wr_ptr` increments on an accepted write.
- Read accept: `rd_acc` = `rd_en` & ~`empty` (pre-edge flag).
  - `ram_adr_b` = (`rd_acc` ? `rd_ptr`+1 : `rd_ptr`)[ADDR_WIDTH-1:0], combinational.
  - The RAM therefore holds the new head address after the edge, and `rd_data` shows the next word in the cycle after the read.
- Write into empty FIFO: data is written at edge N. `empty` falls after edge N, and `rd_data` is valid in the same cycle, because the RAM read port is addressed at `rd_ptr` and reads combinationally after the write lands.
- Simultaneous `rd_acc` & `wr_acc`: both pointers advance and `fill` is unchanged.
  - When full: the read is accepted and the write is rejected (`full` is pre-edge); `fill` decrements.
  - When empty: the write is accepted and the read is rejected; `udf` is set.
- Errors:
  - `ovf` sets on `wr_en` & `full`; rejected data is dropped.
  - `udf` sets on `rd_en` & `empty`; pointers do not move.
  - Both flags are sticky until `rst` or `clear`.
- `clear` (synchronous, priority over `wr_en`/`rd_en`): pointers to 0 and `ovf`/`udf` to 0 at the next edge. `ram_we_a`=0 while `clear`=1. RAM contents are untouched.
- Wrap-around: the low pointer bits wrap 2^ADDR_WIDTH−1 → 0 and the MSB toggles. Data order is preserved across the wrap.
- `rd_data` is undefined while `empty`=1.

Optional Feature:
- Macro: VFIFO_ALMOST_FLAGS_EN.
- Defined:
  - Adds two outputs, `almost_full` and `almost_empty`, each 1 bit and registered.
  - `almost_full` = (next `fill` >= 2^ADDR_WIDTH − AF_THR).
  - `almost_empty` = (next `fill` <= AE_THR).
  - Both update on the same edge as `fill`.
  - Reset values: `almost_full`=0, `almost_empty`=1.
- Not defined: the ports, AF_THR and AE_THR logic are absent; all other behaviour is identical.

Test Plan:
- Assert `rst` mid-run with `fill`=5 -> immediately `empty`=1, `full`=0, `fill`=0, `ovf`=`udf`=0; the first post-reset write lands at `ram_adr_a`=0.
- Write 0x11, 0x22, 0x33 on consecutive cycles into an empty FIFO, with `rd_en`=0:
  - `empty`=0 and `rd_data`=0x11 the cycle after the first write.
  - Then read 3 times -> `rd_data` goes 0x11, 0x22, 0x33; `empty`=1 after the third read; `fill` ends at 0.
- With ADDR_WIDTH=4, write 0x00..0x0F:
  - -> `full`=1, `fill`=16.
  - An extra write of 0xAA -> `ovf`=1, `ram_we_a`=0, and reads return 0x00..0x0F only.
- At `fill`=16, assert `rd_en` and `wr_en` together -> read accepted, write rejected, `fill`=15, `ovf`=1.
- Continuous simultaneous read/write at `fill`=1 for 40 cycles with an incrementing pattern -> `fill` stays 1, output is in order, and the pointers wrap past 15 twice.
- Read while empty -> `udf`=1 and pointers unchanged. Then assert `clear` with `wr_en`=1 -> `udf`=0, `fill`=0, no write performed.
- With VFIFO_ALMOST_FLAGS_EN defined, filling to 14 -> `almost_full`=1 on the edge where `fill`=14.

Source files
------------

// File: rtl/vfifo_sync_ctrl.sv
// Single-clock show-ahead FIFO controller driving an external simple dual-port RAM
// (write port A, registered-address/combinational-data port B). Optional flags: VFIFO_ALMOST_FLAGS_EN.
module vfifo_sync_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THR     = 2,
    parameter int AE_THR     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   fill,
    output logic                  ovf,
    output logic                  udf,
`ifdef VFIFO_ALMOST_FLAGS_EN
    output logic                  almost_full,
    output logic                  almost_empty,
`endif
    output logic [ADDR_WIDTH-1:0] ram_adr_a,
    output logic [DATA_WIDTH-1:0] ram_d_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);
    localparam int PW = ADDR_WIDTH + 1;

    // Handshake: a write is taken on any edge where wr_en=1 and full=0; a read consumes
    // rd_data on any edge where rd_en=1 and empty=0. Both flags are sampled before the edge.
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic          wr_acc, rd_acc;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign fill  = wr_ptr - rd_ptr;

    assign wr_acc = wr_en & ~full  & ~clear & ~rst;
    assign rd_acc = rd_en & ~empty & ~clear & ~rst;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (clear) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_acc) wr_ptr_nxt = wr_ptr + PW'(1);
            if (rd_acc) rd_ptr_nxt = rd_ptr + PW'(1);
        end
    end

    assign ram_we_a  = wr_acc;
    assign ram_adr_a = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_d_a   = wr_data;
    // The RAM registers this address, so present the head the FIFO will have after the edge.
    assign ram_adr_b = rd_ptr_nxt[ADDR_WIDTH-1:0];
    assign rd_data   = ram_q_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (clear) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (wr_en && full)  ovf <= 1'b1;
                if (rd_en && empty) udf <= 1'b1;
            end
        end
    end

`ifdef VFIFO_ALMOST_FLAGS_EN
    localparam logic [PW-1:0] AF_LEVEL = PW'((1 << ADDR_WIDTH) - AF_THR);
    localparam logic [PW-1:0] AE_LEVEL = PW'(AE_THR);

    logic [PW-1:0] fill_nxt;
    assign fill_nxt = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (fill_nxt >= AF_LEVEL);
            almost_empty <= (fill_nxt <= AE_LEVEL);
        end
    end
`endif

endmodule
